// File: rtl/cmp_pair_sequencer_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : cmp_pair_sequencer_pkg
//  Description : Shared state encoding, result codes and the flag encoder
//                used by the comparator operand sequencer.
//  Revision    : 1.0  initial release
// ============================================================================
package cmp_pair_sequencer_pkg;

    typedef enum logic [1:0] {
        LOAD_A  = 2'd0,
        LOAD_B  = 2'd1,
        COMPARE = 2'd2,
        HOLD    = 2'd3
    } seq_state_t;

    localparam logic [1:0] CODE_EQ  = 2'b00;
    localparam logic [1:0] CODE_GT  = 2'b01;
    localparam logic [1:0] CODE_LT  = 2'b10;
    localparam logic [1:0] CODE_ERR = 2'b11;

    // Exactly one comparator flag must be set; any other combination is illegal.
    function automatic logic [1:0] encode_flags(input logic eq,
                                                input logic gt,
                                                input logic lt);
        logic [1:0] code;
        case ({eq, gt, lt})
            3'b100:  code = CODE_EQ;
            3'b010:  code = CODE_GT;
            3'b001:  code = CODE_LT;
            default: code = CODE_ERR;
        endcase
        return code;
    endfunction

endpackage
`default_nettype wire

// File: rtl/cmp_pair_sequencer.sv
`default_nettype none
// ============================================================================
//  Module      : cmp_pair_sequencer
//  Description : Pairs consecutive input samples into comparator operands
//                A and B, captures the comparator flags one cycle later and
//                returns an encoded result over a valid/ready handshake.
//                Counts accepted results and flags illegal flag combinations.
//  Revision    : 1.0  initial release
// ============================================================================
module cmp_pair_sequencer
    import cmp_pair_sequencer_pkg::*;
#(
    parameter int WIDTH = 4,
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    output logic [WIDTH-1:0] cmp_a,
    output logic [WIDTH-1:0] cmp_b,
    input  logic             cmp_equal,
    input  logic             cmp_bigger,
    input  logic             cmp_lower,
    output logic             res_valid,
    input  logic             res_ready,
    output logic [1:0]       res_code,
    output logic [WIDTH-1:0] res_a,
    output logic [WIDTH-1:0] res_b,
    output logic             err_flag,
    output logic [CNT_W-1:0] pair_count
);

    seq_state_t state;
    logic [1:0] flag_code;

    // Input side is open only while an operand slot is waiting to be filled.
    assign in_ready  = (state == LOAD_A) || (state == LOAD_B);

    // Comparator flags encoded continuously; only consumed in COMPARE.
    assign flag_code = encode_flags(cmp_equal, cmp_bigger, cmp_lower);

    // Sequencer: load A, load B, one settle/capture cycle, then hold the result.
    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= LOAD_A;
            cmp_a      <= '0;
            cmp_b      <= '0;
            res_a      <= '0;
            res_b      <= '0;
            res_code   <= CODE_EQ;
            res_valid  <= 1'b0;
            err_flag   <= 1'b0;
            pair_count <= '0;
        end else begin
            case (state)
                LOAD_A: begin
                    if (in_valid) begin
                        cmp_a <= in_data;
                        state <= LOAD_B;
                    end
                end
                LOAD_B: begin
                    if (in_valid) begin
                        cmp_b <= in_data;
                        state <= COMPARE;
                    end
                end
                COMPARE: begin
                    // Operands have been stable for a full cycle here.
                    res_a     <= cmp_a;
                    res_b     <= cmp_b;
                    res_code  <= flag_code;
                    res_valid <= 1'b1;
                    if (flag_code == CODE_ERR) begin
                        err_flag <= 1'b1;
                    end
                    state <= HOLD;
                end
                HOLD: begin
                    if (res_valid && res_ready) begin
                        res_valid  <= 1'b0;
                        pair_count <= pair_count + CNT_W'(1);
                        state      <= LOAD_A;
                    end
                end
                default: begin
                    state <= LOAD_A;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_cmp_pair_sequencer.sv
`default_nettype none
// ============================================================================
//  Module      : tb_cmp_pair_sequencer
//  Description : Self-checking bench for cmp_pair_sequencer with a
//                behavioural 4-bit magnitude comparator beside it.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_cmp_pair_sequencer;

    logic       clk = 1'b0;
    logic       rst;
    logic       in_valid;
    logic [3:0] in_data;
    logic       res_ready;

    logic       in_ready, in_ready2;
    logic [3:0] cmp_a, cmp_b, cmp_a2, cmp_b2;
    logic       cmp_equal, cmp_bigger, cmp_lower;
    logic       res_valid, res_valid2;
    logic [1:0] res_code, res_code2;
    logic [3:0] res_a, res_b, res_a2, res_b2;
    logic       err_flag, err_flag2;
    logic [7:0] pair_count;
    logic [1:0] pair_count2;

    // Comparator model, with an override so illegal flag sets can be injected.
    logic force_en, f_eq, f_gt, f_lt;
    assign cmp_equal  = force_en ? f_eq : (cmp_a == cmp_b);
    assign cmp_bigger = force_en ? f_gt : (cmp_a >  cmp_b);
    assign cmp_lower  = force_en ? f_lt : (cmp_a <  cmp_b);

    int checks = 0;
    int errors = 0;
    int exp_cnt = 0;

    always #5 clk = ~clk;

    cmp_pair_sequencer #(.WIDTH(4), .CNT_W(8)) dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
        .cmp_a(cmp_a), .cmp_b(cmp_b),
        .cmp_equal(cmp_equal), .cmp_bigger(cmp_bigger), .cmp_lower(cmp_lower),
        .res_valid(res_valid), .res_ready(res_ready), .res_code(res_code),
        .res_a(res_a), .res_b(res_b),
        .err_flag(err_flag), .pair_count(pair_count)
    );

    // Narrow-counter copy running in lockstep to exercise the wrap.
    cmp_pair_sequencer #(.WIDTH(4), .CNT_W(2)) dut2 (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready2), .in_data(in_data),
        .cmp_a(cmp_a2), .cmp_b(cmp_b2),
        .cmp_equal(cmp_equal), .cmp_bigger(cmp_bigger), .cmp_lower(cmp_lower),
        .res_valid(res_valid2), .res_ready(res_ready), .res_code(res_code2),
        .res_a(res_a2), .res_b(res_b2),
        .err_flag(err_flag2), .pair_count(pair_count2)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    // Reference result code from the operand values or the forced flags.
    function automatic logic [1:0] ref_code(input logic [3:0] a, input logic [3:0] b);
        if (force_en) begin
            if (f_eq && !f_gt && !f_lt) return 2'b00;
            if (!f_eq && f_gt && !f_lt) return 2'b01;
            if (!f_eq && !f_gt && f_lt) return 2'b10;
            return 2'b11;
        end
        if (a == b) return 2'b00;
        if (a > b)  return 2'b01;
        return 2'b10;
    endfunction

    task automatic send(input logic [3:0] d);
        int n = 0;
        in_valid = 1'b1;
        in_data  = d;
        while (!in_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (n >= 50) check("send_timeout", 32'd1, 32'd0);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        in_data  = 4'($urandom);
    endtask

    task automatic get_result(input logic [3:0] a, input logic [3:0] b, input int hold);
        int n = 0;
        logic [1:0] ec;
        ec = ref_code(a, b);
        @(negedge clk);
        while (!res_valid && n < 50) begin
            @(negedge clk);
            n++;
        end
        check("latency", n, 1);
        check("res_code", res_code, ec);
        check("res_a", res_a, a);
        check("res_b", res_b, b);
        check("res_code_w2", res_code2, ec);
        for (int i = 0; i < hold; i++) begin
            in_valid = 1'b1;
            in_data  = 4'($urandom);
            @(negedge clk);
            check("hold_valid", res_valid, 1);
            check("hold_code", res_code, ec);
            check("hold_in_ready", in_ready, 0);
            check("hold_cmp_a", cmp_a, a);
        end
        in_valid  = 1'b0;
        res_ready = 1'b1;
        @(posedge clk);
        #1;
        res_ready = 1'b0;
        exp_cnt++;
        @(negedge clk);
        check("post_valid", res_valid, 0);
        check("post_in_ready", in_ready, 1);
        check("pair_count", pair_count, 32'(exp_cnt % 256));
        check("pair_count_w2", pair_count2, 32'(exp_cnt % 4));
    endtask

    task automatic do_pair(input logic [3:0] a, input logic [3:0] b, input int hold);
        send(a);
        send(b);
        get_result(a, b, hold);
    endtask

    task automatic pulse_rst();
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        exp_cnt = 0;
        @(negedge clk);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1; in_valid = 1'b0; in_data = 4'd0; res_ready = 1'b0;
        force_en = 1'b0; f_eq = 1'b0; f_gt = 1'b0; f_lt = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        check("rst_in_ready", in_ready, 1);
        check("rst_res_valid", res_valid, 0);
        check("rst_cmp_a", cmp_a, 0);
        check("rst_cmp_b", cmp_b, 0);
        check("rst_res_code", res_code, 0);
        check("rst_res_ab", {res_a, res_b}, 0);
        check("rst_pair_count", pair_count, 0);
        check("rst_err", err_flag, 0);

        // Directed pairs: lower, bigger, equal, then a held result.
        do_pair(4'b0011, 4'b0100, 0);
        check("err_legal", err_flag, 0);
        do_pair(4'b0101, 4'b0100, 0);
        do_pair(4'b0110, 4'b0110, 0);
        do_pair(4'b0111, 4'b0010, 5);

        // Half-loaded pair discarded by reset.
        send(4'b1010);
        pulse_rst();
        check("rst_mid_cmp_a", cmp_a, 0);
        check("rst_mid_in_ready", in_ready, 1);
        do_pair(4'b0001, 4'b0010, 0);

        // Illegal comparator flags.
        force_en = 1'b1; f_eq = 1'b1; f_gt = 1'b1; f_lt = 1'b0;
        do_pair(4'b1001, 4'b0011, 0);
        check("err_set", err_flag, 1);
        check("err_set_w2", err_flag2, 1);
        force_en = 1'b0;
        do_pair(4'b0100, 4'b0100, 1);
        check("err_sticky", err_flag, 1);

        // Pending result dropped by reset; reset also clears the error flag.
        send(4'b0001);
        send(4'b0010);
        repeat (2) @(negedge clk);
        check("pending_valid", res_valid, 1);
        pulse_rst();
        check("drop_valid", res_valid, 0);
        check("drop_err", err_flag, 0);
        check("drop_count", pair_count, 0);

        // Randomized pairs against the reference model.
        for (int k = 0; k < 24; k++) begin
            logic [3:0] a, b;
            a = 4'($urandom);
            b = (k % 4 == 0) ? a : 4'($urandom);
            do_pair(a, b, int'($urandom_range(0, 2)));
        end
        check("rand_err", err_flag, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
